cmp3_sweep_checker: RTL and testbench

Sequential stimulus generator and response checker for the 3-bit signed comparator (inputs a0..a2, b0..b2; outputs E, L, G).
- Drives the operand side: walks all 64 {a,b} combinations in order.
- Consumes the result side: samples E/L/G and checks them against a golden two's-complement compare.
- Reports pass/fail, error count and the first failing vector.
- Sits next to the comparator in the lab top level and replaces manual switch testing.

---
 rtl/cmp3_sweep_checker.sv | 143 ++++++++++++++
 tb/tb_cmp3_sweep_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp3_sweep_checker.sv
// cmp3_sweep_checker: walks all 64 {a,b} operand pairs into a 3-bit signed
// comparator and checks its E/L/G response against a two's-complement
// golden compare. It reports pass/fail, an error count and the first
// failing vector.
// Optional build macro CMP3_STOP_ON_FAIL_EN: when it is defined, the sweep
// ends at the first failing vector and leaves that vector on the operand
// outputs for probing.
module cmp3_sweep_checker #(
    parameter int unsigned SETTLE = 2   // hold cycles per vector before sampling (1..15)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       b0,
    output logic       b1,
    output logic       b2,
    input  logic       E,
    input  logic       L,
    input  logic       G,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic       first_fail_valid,
    output logic [5:0] first_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q;
    logic [5:0]  vec_q;
    logic [3:0]  settle_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [6:0]  err_q;
    logic        ffv_q;
    logic [5:0]  ffvec_q;

    logic signed [2:0] sa_d;
    logic signed [2:0] sb_d;
    logic [2:0]        exp_d;
    logic              mismatch_d;

    // Golden two's-complement compare of the vector currently driven.
    always_comb begin
        sa_d       = vec_q[5:3];
        sb_d       = vec_q[2:0];
        exp_d      = {(sa_d == sb_d), (sa_d < sb_d), (sa_d > sb_d)};
        mismatch_d = ({E, L, G} != exp_d);
    end

    // Sweep sequencer. DONE raises done/pass one cycle after it is entered,
    // and busy stays high until then, so start is accepted only after done
    // is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pass_q <= (err_q == 7'd0);
                    end
                    if (start && !busy_q) begin
                        state_q  <= S_DRIVE;
                        vec_q    <= '0;
                        settle_q <= '0;
                        err_q    <= '0;
                        ffv_q    <= 1'b0;
                        ffvec_q  <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= S_CHECK;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch_d) begin
                        if (err_q != 7'd127) err_q <= err_q + 7'd1;
                        if (!ffv_q) begin
                            ffv_q   <= 1'b1;
                            ffvec_q <= vec_q;
                        end
                    end
`ifdef CMP3_STOP_ON_FAIL_EN
                    if (mismatch_d || vec_q == 6'd63) begin
                        state_q <= S_DONE;
                    end else begin
                        vec_q    <= vec_q + 6'd1;
                        settle_q <= '0;
                        state_q  <= S_DRIVE;
                    end
`else
                    if (vec_q == 6'd63) begin
                        state_q <= S_DONE;
                    end else begin
                        vec_q    <= vec_q + 6'd1;
                        settle_q <= '0;
                        state_q  <= S_DRIVE;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign {a0, a1, a2, b0, b1, b2} = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_cmp3_sweep_checker.sv
// Bench for cmp3_sweep_checker: a behavioural comparator with selectable
// fault modes drives E/L/G. Each sweep is compared against an expectation
// that is worked out from the fault model over all 64 vectors.
module tb_cmp3_sweep_checker;
    localparam int SETTLE = 2;
    localparam int FULL_CYC = 64 * (SETTLE + 1) + 1;

    logic clk = 1'b0;
    logic reset, start;
    logic a0, a1, a2, b0, b1, b2;
    logic E, L, G;
    logic busy, done, pass, first_fail_valid;
    logic [6:0] err_count;
    logic [5:0] first_fail_vec;

    int checks = 0;
    int errors = 0;
    int mode;
    logic [63:0][2:0] mask;
    logic [5:0] drv;

    always #5 clk = ~clk;

    cmp3_sweep_checker #(.SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .E(E), .L(L), .G(G),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
    );

    assign drv = {a0, a1, a2, b0, b1, b2};

    function automatic int sval(input logic [2:0] x);
        return x[2] ? int'(x) - 8 : int'(x);
    endfunction

    function automatic logic [2:0] ideal(input logic [5:0] v);
        int a, b;
        a = sval(v[5:3]);
        b = sval(v[2:0]);
        return {a == b, a < b, a > b};
    endfunction

    // 0 ideal, 1 E stuck 0, 2 L/G swapped, 3 all ones, 4 G stuck 1, 5 random xor faults
    function automatic logic [2:0] resp(input int m, input logic [63:0][2:0] mk,
                                        input logic [5:0] v);
        logic [2:0] i;
        i = ideal(v);
        case (m)
            1: return i & 3'b011;
            2: return {i[2], i[0], i[1]};
            3: return 3'b111;
            4: return i | 3'b001;
            5: return i ^ mk[v];
            default: return i;
        endcase
    endfunction

    assign {E, L, G} = resp(mode, mask, drv);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 2000 && done !== 1'b1) begin
            tick();
            n++;
        end
    endtask

    // Expectation from the fault model: which vectors respond wrongly.
    task automatic verify(input string tag, input int n);
        int cnt, first, exp_err, exp_cyc;
        logic [5:0] exp_hold;
        cnt = 0;
        first = -1;
        for (int v = 0; v < 64; v++) begin
            if (resp(mode, mask, 6'(v)) !== ideal(6'(v))) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
`ifdef CMP3_STOP_ON_FAIL_EN
        exp_err  = (cnt > 0) ? 1 : 0;
        exp_cyc  = (cnt > 0) ? (first + 1) * (SETTLE + 1) + 1 : FULL_CYC;
        exp_hold = (cnt > 0) ? 6'(first) : 6'd63;
`else
        exp_err  = cnt;
        exp_cyc  = FULL_CYC;
        exp_hold = 6'd63;
`endif
        chk({tag, ".cycles"}, n, exp_cyc);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".pass"}, pass, (exp_err == 0) ? 1 : 0);
        chk({tag, ".err_count"}, err_count, exp_err);
        chk({tag, ".ffv"}, first_fail_valid, (cnt > 0) ? 1 : 0);
        chk({tag, ".ffvec"}, first_fail_vec, (cnt > 0) ? first : 0);
        chk({tag, ".hold"}, drv, exp_hold);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        mask  = '0;
        tick();
        tick();
        chk("rst.drv", drv, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.err", err_count, 0);
        chk("rst.ffv", first_fail_valid, 0);
        chk("rst.ffvec", first_fail_vec, 0);
        reset = 1'b0;
        tick();

        // 1: ideal comparator, done held afterwards
        mode = 0;
        pulse_start();
        chk("t1.busy_after_start", busy, 1);
        wait_done(n);
        verify("t1", n);
        repeat (5) tick();
        chk("t1.done_held", done, 1);
        chk("t1.hold_held", drv, 63);

        // 2: E stuck at 0
        mode = 1;
        pulse_start();
        wait_done(n);
        verify("t2", n);

        // 3: L and G swapped
        mode = 2;
        pulse_start();
        wait_done(n);
        verify("t3", n);

        // 4: all flags high, then a second start clears the counters
        mode = 3;
        pulse_start();
        wait_done(n);
        verify("t4", n);
        mode = 0;
        pulse_start();
        chk("t4.restart_err", err_count, 0);
        chk("t4.restart_ffv", first_fail_valid, 0);
        chk("t4.restart_ffvec", first_fail_vec, 0);
        chk("t4.restart_busy", busy, 1);
        chk("t4.restart_done", done, 0);
        wait_done(n);
        verify("t4b", n);

        // 5: start ignored while busy; reset mid-sweep at vec 20
        mode = 0;
        pulse_start();
        n = 0;
        while (n < 500 && drv != 6'd5) begin tick(); n++; end
        chk("t5.reach5", drv, 5);
        pulse_start();
        chk("t5.no_restart", (drv >= 6'd5) ? 1 : 0, 1);
        n = 0;
        while (n < 500 && drv != 6'd20) begin tick(); n++; end
        chk("t5.reach20", drv, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5.rst_drv", drv, 0);
        chk("t5.rst_busy", busy, 0);
        chk("t5.rst_done", done, 0);
        chk("t5.rst_err", err_count, 0);
        chk("t5.rst_ffv", first_fail_valid, 0);
        repeat (4) tick();
        chk("t5.idle_drv", drv, 0);
        chk("t5.idle_done", done, 0);
        pulse_start();
        wait_done(n);
        verify("t5", n);

        // 6: G stuck at 1 (early stop when the optional feature is built in)
        mode = 4;
        pulse_start();
        wait_done(n);
        verify("t6", n);

        // random xor fault patterns
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 64; v++)
                mask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            mode = 5;
            pulse_start();
            wait_done(n);
            verify("rnd", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
